// File: rtl/clock_time_keeper.sv
// Time-of-day core: synchronised 1 Hz tick, BCD hh:mm:ss,
// button-driven set mode and digit-blink flags for the scanner.
module clock_time_keeper #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  RESET_HOUR  = 8'h00,
    parameter logic [7:0]  RESET_MIN   = 8'h00
) (
    input  logic       clk_in_50M,
    input  logic       rst_n,
    input  logic       tick_1hz_in,
    input  logic       blink_4hz_in,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [7:0] hour_bcd,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic [1:0] mode,
    output logic       blank_hour,
    output logic       blank_min,
    output logic       sec_pulse,
    output logic       day_pulse
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2
    } mode_e;

    logic [SYNC_STAGES-1:0] tick_sync_q;
    logic [SYNC_STAGES-1:0] blink_sync_q;
    logic                   tick_hist_q;
    logic                   mode_btn_q;
    logic                   inc_btn_q;
    logic                   mode_edge_q;
    logic                   inc_edge_q;
    logic                   tick_en;

    mode_e      mode_q, mode_d;
    logic [7:0] hour_q, hour_d;
    logic [7:0] min_q, min_d;
    logic [7:0] sec_q, sec_d;
    logic       sec_pulse_q, sec_pulse_d;
    logic       day_pulse_q, day_pulse_d;
    logic       blank_hour_q, blank_min_q;

    // Two-digit BCD increment that wraps to 00 after max.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v,
                                           input logic [7:0] max);
        if (v == max)
            return 8'h00;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'h0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    assign tick_en = tick_sync_q[SYNC_STAGES-1] & ~tick_hist_q;

    always_comb begin
        mode_d      = mode_q;
        hour_d      = hour_q;
        min_d       = min_q;
        sec_d       = sec_q;
        sec_pulse_d = 1'b0;
        day_pulse_d = 1'b0;
        if (mode_edge_q) begin
            unique case (mode_q)
                RUN: begin
                    mode_d = SET_HOUR;
                    sec_d  = 8'h00;
                end
                SET_HOUR: mode_d = SET_MIN;
                default:  mode_d = RUN;
            endcase
        end else begin
            unique case (mode_q)
                RUN: begin
                    if (tick_en) begin
                        sec_d       = bcd_inc(sec_q, 8'h59);
                        sec_pulse_d = 1'b1;
                        if (sec_q == 8'h59) begin
                            min_d = bcd_inc(min_q, 8'h59);
                            if (min_q == 8'h59) begin
                                hour_d      = bcd_inc(hour_q, 8'h23);
                                day_pulse_d = (hour_q == 8'h23);
                            end
                        end
                    end
                end
                SET_HOUR: begin
                    if (inc_edge_q)
                        hour_d = bcd_inc(hour_q, 8'h23);
                end
                default: begin
                    if (inc_edge_q)
                        min_d = bcd_inc(min_q, 8'h59);
                end
            endcase
        end
    end

    always_ff @(posedge clk_in_50M or negedge rst_n) begin
        if (!rst_n) begin
            tick_sync_q  <= '0;
            blink_sync_q <= '0;
            tick_hist_q  <= 1'b0;
            mode_btn_q   <= 1'b0;
            inc_btn_q    <= 1'b0;
            mode_edge_q  <= 1'b0;
            inc_edge_q   <= 1'b0;
            mode_q       <= RUN;
            hour_q       <= RESET_HOUR;
            min_q        <= RESET_MIN;
            sec_q        <= 8'h00;
            sec_pulse_q  <= 1'b0;
            day_pulse_q  <= 1'b0;
            blank_hour_q <= 1'b0;
            blank_min_q  <= 1'b0;
        end else begin
            tick_sync_q  <= {tick_sync_q[SYNC_STAGES-2:0], tick_1hz_in};
            blink_sync_q <= {blink_sync_q[SYNC_STAGES-2:0], blink_4hz_in};
            tick_hist_q  <= tick_sync_q[SYNC_STAGES-1];
            mode_btn_q   <= btn_mode;
            inc_btn_q    <= btn_inc;
            mode_edge_q  <= btn_mode & ~mode_btn_q;
            inc_edge_q   <= btn_inc & ~inc_btn_q;
            mode_q       <= mode_d;
            hour_q       <= hour_d;
            min_q        <= min_d;
            sec_q        <= sec_d;
            sec_pulse_q  <= sec_pulse_d;
            day_pulse_q  <= day_pulse_d;
            blank_hour_q <= (mode_q == SET_HOUR) & blink_sync_q[SYNC_STAGES-1];
            blank_min_q  <= (mode_q == SET_MIN) & blink_sync_q[SYNC_STAGES-1];
        end
    end

    assign hour_bcd   = hour_q;
    assign min_bcd    = min_q;
    assign sec_bcd    = sec_q;
    assign mode       = mode_q;
    assign blank_hour = blank_hour_q;
    assign blank_min  = blank_min_q;
    assign sec_pulse  = sec_pulse_q;
    assign day_pulse  = day_pulse_q;

endmodule

// File: tb/tb_clock_time_keeper.sv
// Bench for clock_time_keeper: vector table of button/tick steps
// plus hand-written pulse, blink and reset sequences.
module tb_clock_time_keeper;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic       blink = 1'b0;
    logic       bm = 1'b0;
    logic       bi = 1'b0;
    logic [7:0] hour, minute, sec;
    logic [1:0] mode;
    logic       bh, bmn, sp, dp;

    int checks = 0;
    int errors = 0;
    int sp_cnt = 0;
    int dp_cnt = 0;
    int s0, d0;

    typedef struct {
        string      nm;
        logic [7:0] h, m, s;
        logic [1:0] md;
    } exp_t;

    typedef struct {
        string      nm;
        int         nmode, ninc, nticks;
        logic [7:0] h, m, s;
        logic [1:0] md;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[$];

    always #10 clk = ~clk;

    clock_time_keeper #(
        .SYNC_STAGES(2),
        .RESET_HOUR (8'h23),
        .RESET_MIN  (8'h59)
    ) dut (
        .clk_in_50M  (clk),
        .rst_n       (rst_n),
        .tick_1hz_in (tick),
        .blink_4hz_in(blink),
        .btn_mode    (bm),
        .btn_inc     (bi),
        .hour_bcd    (hour),
        .min_bcd     (minute),
        .sec_bcd     (sec),
        .mode        (mode),
        .blank_hour  (bh),
        .blank_min   (bmn),
        .sec_pulse   (sp),
        .day_pulse   (dp)
    );

    always @(posedge clk) begin
        if (sp) sp_cnt++;
        if (dp) dp_cnt++;
    end

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", nm, got, exp);
        end
    endtask

    task automatic push(input string nm, input logic [7:0] h,
                        input logic [7:0] m, input logic [7:0] s,
                        input logic [1:0] md);
        exp_t e;
        e.nm = nm; e.h = h; e.m = m; e.s = s; e.md = md;
        sb.push_back(e);
    endtask

    task automatic pop_chk();
        exp_t e;
        e = sb.pop_front();
        chk(e.nm, {hour, minute, sec, 6'b0, mode},
            {e.h, e.m, e.s, 6'b0, e.md});
    endtask

    task automatic add(input string nm, input int nmode, input int ninc,
                       input int nticks, input logic [7:0] h,
                       input logic [7:0] m, input logic [7:0] s,
                       input logic [1:0] md);
        vec_t v;
        v.nm = nm; v.nmode = nmode; v.ninc = ninc; v.nticks = nticks;
        v.h = h; v.m = m; v.s = s; v.md = md;
        tbl.push_back(v);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic m, input logic i);
        @(negedge clk);
        bm = m; bi = i;
        cyc(3);
        bm = 1'b0; bi = 1'b0;
        cyc(3);
    endtask

    task automatic pulse_tick();
        @(negedge clk);
        tick = 1'b1;
        cyc(4);
        tick = 1'b0;
        cyc(4);
    endtask

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            repeat (tbl[i].nmode) press(1'b1, 1'b0);
            repeat (tbl[i].ninc) press(1'b0, 1'b1);
            repeat (tbl[i].nticks) pulse_tick();
            push(tbl[i].nm, tbl[i].h, tbl[i].m, tbl[i].s, tbl[i].md);
            pop_chk();
        end
    endtask

    initial begin
        add("set_hr",     1, 0,  0, 8'h23, 8'h59, 8'h00, 2'd1);
        add("hr_wrap24",  0, 24, 0, 8'h23, 8'h59, 8'h00, 2'd1);
        add("to_setmin",  1, 0,  0, 8'h23, 8'h59, 8'h00, 2'd2);
        add("min_wrap60", 0, 60, 0, 8'h23, 8'h59, 8'h00, 2'd2);
        add("to_run",     1, 0,  0, 8'h23, 8'h59, 8'h00, 2'd0);
        add("inc_in_run", 0, 2,  0, 8'h23, 8'h59, 8'h00, 2'd0);
        add("t59",        0, 0, 59, 8'h23, 8'h59, 8'h59, 2'd0);
        add("sec09",      0, 0,  8, 8'h00, 8'h00, 8'h09, 2'd0);
        add("sec10",      0, 0,  1, 8'h00, 8'h00, 8'h10, 2'd0);
        add("sec59",      0, 0, 49, 8'h00, 8'h00, 8'h59, 2'd0);
        add("min_carry",  0, 0,  1, 8'h00, 8'h01, 8'h00, 2'd0);
        add("to_sethr",   1, 0,  0, 8'h00, 8'h01, 8'h00, 2'd1);
        add("hr12",       0, 12, 0, 8'h12, 8'h01, 8'h00, 2'd1);
        add("to_setmin2", 1, 0,  0, 8'h12, 8'h01, 8'h00, 2'd2);
        add("min34",      0, 33, 0, 8'h12, 8'h34, 8'h00, 2'd2);
        add("to_run2",    1, 0,  0, 8'h12, 8'h34, 8'h00, 2'd0);
        add("t56",        0, 0, 56, 8'h12, 8'h34, 8'h56, 2'd0);
        add("freeze",     1, 0,  3, 8'h12, 8'h34, 8'h00, 2'd1);
        add("hr25",       0, 25, 0, 8'h13, 8'h34, 8'h00, 2'd1);
        add("to_setmin3", 1, 0,  0, 8'h13, 8'h34, 8'h00, 2'd2);
        add("min30",      0, 30, 0, 8'h13, 8'h04, 8'h00, 2'd2);
        add("to_run3",    1, 0,  0, 8'h13, 8'h04, 8'h00, 2'd0);
        add("to_sethr3",  1, 0,  0, 8'h13, 8'h04, 8'h00, 2'd1);

        cyc(3);
        push("reset", 8'h23, 8'h59, 8'h00, 2'd0);
        pop_chk();
        chk("reset_flags", {28'd0, bh, bmn, sp, dp}, 32'd0);
        rst_n = 1'b1;
        cyc(2);

        // First tick after reset: update lands two edges after sampling.
        @(negedge clk);
        tick = 1'b1;
        cyc(2);
        chk("tick_lat_sec", {24'd0, sec}, 32'h00);
        chk("tick_lat_sp", {31'd0, sp}, 32'd0);
        cyc(1);
        push("tick1", 8'h23, 8'h59, 8'h01, 2'd0);
        pop_chk();
        chk("tick1_pulses", {30'd0, sp, dp}, 32'b10);
        cyc(1);
        chk("tick1_sp_once", {31'd0, sp}, 32'd0);
        tick = 1'b0;
        cyc(4);

        run_vecs(0, 6);
        chk("no_day_yet", dp_cnt, 0);

        d0 = dp_cnt;
        @(negedge clk);
        tick = 1'b1;
        cyc(2);
        chk("roll_pre", {24'd0, sec}, 32'h59);
        cyc(1);
        push("rollover", 8'h00, 8'h00, 8'h00, 2'd0);
        pop_chk();
        chk("roll_pulses", {30'd0, sp, dp}, 32'b11);
        cyc(1);
        chk("roll_pulses_off", {30'd0, sp, dp}, 32'b00);
        tick = 1'b0;
        cyc(4);
        chk("day_cnt", dp_cnt - d0, 1);

        s0 = sp_cnt;
        @(negedge clk);
        tick = 1'b1;
        cyc(10000);
        tick = 1'b0;
        cyc(4);
        push("held_tick", 8'h00, 8'h00, 8'h01, 2'd0);
        pop_chk();
        chk("held_pulses", sp_cnt - s0, 1);

        run_vecs(7, 16);
        s0 = sp_cnt;
        run_vecs(17, 22);
        chk("set_no_sp", sp_cnt - s0, 0);

        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            blink = ~blink;
            cyc(2);
            chk("blink_hold", {31'd0, bh}, {31'd0, ~blink});
            cyc(1);
            chk("blink_follow", {31'd0, bh}, {31'd0, blink});
            chk("blink_min0", {31'd0, bmn}, 32'd0);
        end

        press(1'b1, 1'b1);
        push("mode_beats_inc", 8'h13, 8'h04, 8'h00, 2'd2);
        pop_chk();

        @(negedge clk);
        blink = 1'b1;
        cyc(4);
        chk("setmin_blank", {30'd0, bh, bmn}, 32'b01);
        press(1'b0, 1'b1);
        press(1'b0, 1'b1);
        push("setmin_inc2", 8'h13, 8'h06, 8'h00, 2'd2);
        pop_chk();

        @(negedge clk);
        rst_n = 1'b0;
        #1;
        push("mid_reset", 8'h23, 8'h59, 8'h00, 2'd0);
        pop_chk();
        chk("mid_reset_flags", {28'd0, bh, bmn, sp, dp}, 32'd0);
        cyc(2);
        rst_n = 1'b1;
        cyc(5);
        chk("run_blank", {30'd0, bh, bmn}, 32'd0);
        push("post_reset", 8'h23, 8'h59, 8'h00, 2'd0);
        pop_chk();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clock_time_keeper.md
Name: clock_time_keeper

Overview:
Time-of-day core of the digital clock. It sits directly downstream of clk_divider and runs entirely in the 50 MHz domain. The divider's clk_out_1Hz and clk_out_4Hz outputs are treated as asynchronous level inputs, synchronised, and edge-detected into enables. The block keeps BCD hours/minutes/seconds, provides a button-driven set mode with digit-blink flags, and feeds the display scanner.

Parameters:
SYNC_STAGES, 2, synchroniser depth for tick_1hz_in and blink_4hz_in (legal range 2..4)
RESET_HOUR, 8'h00, BCD hour loaded on reset (legal 8'h00..8'h23)
RESET_MIN, 8'h00, BCD minute loaded on reset (legal 8'h00..8'h59)

Ports:
clk_in_50M  input  1  system clock, 50 MHz
rst_n  input  1  asynchronous active-low reset
tick_1hz_in  input  1  clk_out_1Hz from clk_divider, asynchronous square wave
blink_4hz_in  input  1  clk_out_4Hz from clk_divider, asynchronous square wave
btn_mode  input  1  debounced level, high while pressed
btn_inc  input  1  debounced level, high while pressed
hour_bcd  output  8  tens[7:4] units[3:0], 00..23
min_bcd  output  8  00..59
sec_bcd  output  8  00..59
mode  output  2  0=RUN, 1=SET_HOUR, 2=SET_MIN
blank_hour  output  1  high = suppress hour digits this cycle
blank_min  output  1  high = suppress minute digits this cycle
sec_pulse  output  1  one-cycle strobe when seconds advance in RUN
day_pulse  output  1  one-cycle strobe on 23:59:59 -> 00:00:00

Behaviour:
- Reset (async assert, sync release):
  - hour=RESET_HOUR, min=RESET_MIN, sec=8'h00, mode=RUN.
  - blank_*=0, sec_pulse=0, day_pulse=0.
  - All synchroniser and edge-detect flops cleared.
- Tick enable:
  - tick_1hz_in passes through SYNC_STAGES flops, then one history flop.
  - tick_en = synced & ~history.
  - With SYNC_STAGES=2, an input rise first sampled at edge k updates sec_bcd at edge k+2.
  - One increment per input rising edge; falling edges are ignored.
- Buttons:
  - Rising-edge detect on btn_mode and btn_inc, one register stage: press seen at edge k acts at edge k+1.
  - A held button acts exactly once.
- State machine, on mode_edge:
  - RUN -> SET_HOUR: sec cleared to 00 on the same edge.
  - SET_HOUR -> SET_MIN.
  - SET_MIN -> RUN.
- RUN:
  - On tick_en, sec+1 with BCD units wrap 9->0 carrying into tens.
  - sec 59 -> 00 carries to min; min 59 -> 00 carries to hour; hour 23 -> 00.
  - All cascaded carries resolve in the same edge.
  - btn_inc is ignored in RUN.
- SET_HOUR / SET_MIN:
  - Seconds frozen at 00 and tick_en ignored.
  - inc_edge increments hour (23 -> 00) or min (59 -> 00).
  - No carry into the neighbouring field; sec_pulse and day_pulse stay 0.
- Simultaneous mode_edge and inc_edge: mode transition wins and inc is dropped.
- Simultaneous mode_edge (RUN -> SET_HOUR) and tick_en: the clear to 00 wins and there is no carry.
- sec_pulse is registered and high for the cycle after the seconds register updates in RUN.
- day_pulse is registered and high for that same cycle only when the update produced 00:00:00 from 23:59:59.
- Blink flags:
  - blink_4hz_in is synchronised with SYNC_STAGES flops (no edge detect).
  - blank_hour = (mode==SET_HOUR) & blink_sync; blank_min = (mode==SET_MIN) & blink_sync.
  - Both are registered, so they go to 0 the cycle after mode leaves the respective state.
- BCD digits never take values A..F. Invalid parameter values are a configuration error and need no handling.
- Reset mid-operation (any state, mid-carry) returns immediately to the reset values. The first tick after release is counted only if the synchronised input rises after release.

Test Plan:
- Reset at RESET_HOUR=8'h23, RESET_MIN=8'h59: release, apply one 1 Hz rising edge -> 2 cycles later outputs 23:59:01, sec_pulse=1 for 1 cycle, day_pulse=0.
- Preload 23:59:59 via set mode (hour 23, min 59), return to RUN, then let 59 ticks pass -> next tick gives 00:00:00, with sec_pulse and day_pulse both high in the same single cycle.
- Hold tick_1hz_in high for 10,000 cycles -> exactly one increment. Seconds 09 -> 10 and 59 -> 00 with min+1 verified.
- btn_mode press from RUN at 12:34:56 -> mode=1, sec=00, frozen through 3 ticks. 25 inc presses -> hour 13 (wraps past 23). Mode press -> mode=2; 30 inc presses -> min 04 and hour stays 13. Mode press -> RUN.
- blink_4hz_in toggling in SET_HOUR -> blank_hour follows blink delayed SYNC_STAGES+1 cycles and blank_min=0. In RUN both are 0.
- Same-cycle btn_mode and btn_inc rises in SET_HOUR -> mode=2 and hour unchanged. rst_n low mid-SET_MIN -> immediate RESET values and mode=0.
